axi_adapter_arb_32: RTL and testbench
=====================================

// Module: axi_adapter_arb_32
// PURPOSE
//  Round-robin arbiter sharing one axi_adapter_32 request port among NR_PORTS requesters
//  (icache refill, dcache refill/writeback, uncached bypass). The adapter serves one
//  transaction at a time, so the arbiter latches the winner's payload, drives the adapter
//  until its valid, and routes gnt/valid/critical word back to the owning port only.
// PARAMETERS
//  NR_PORTS      3   number of requesters (2..8)
//  DATA_WIDTH    64  cacheline payload width in bits, multiple of 32 (matches adapter)
//  AXI_ID_WIDTH  4   transaction ID width (matches adapter)
// PORTS
//  clk_i                  in   1                   clock
//  rst_ni                 in   1                   async reset, active low
//  req_i                  in   NR_PORTS            per-port request, held until gnt_o
//  type_i                 in   NR_PORTS x ad_req_t SINGLE_REQ / cacheline request
//  addr_i                 in   NR_PORTS x 32       byte address
//  we_i                   in   NR_PORTS            1 = write
//  wdata_i / be_i         in   NR_PORTS x DW / DW/8 write data / byte enables
//  size_i                 in   NR_PORTS x 2        AXI size
//  id_i                   in   NR_PORTS x ID       transaction ID
//  gnt_o                  out  NR_PORTS            one-hot, one cycle, mirrors adapter gnt
//  valid_o                out  NR_PORTS            one-hot, one cycle, completion to owner
//  rdata_o / id_o         out  DW / ID             shared; meaningful when valid_o != 0
//  critical_word_o        out  32                  shared critical word
//  critical_word_valid_o  out  NR_PORTS            one-hot, owner only
//  adp_req_o ... adp_id_o out  (adapter widths)    request/type/addr/we/wdata/be/size/id to adapter
//  adp_gnt_i, adp_valid_i in   1                   adapter grant / completion
//  adp_rdata_i, adp_id_i, adp_cw_i, adp_cw_valid_i in  adapter read-side outputs
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, owner 0, payload reg 0; all gnt_o/valid_o/
//   critical_word_valid_o/adp_req_o = 0. Reset mid-transaction abandons it silently.
//  FSM IDLE -> REQ -> RESP -> IDLE.
//  IDLE: if any req_i, pick first set bit at or after rr pointer (wrapping mod NR_PORTS);
//   store owner, capture owner's full payload in one register; -> REQ. adp_req_o = 0.
//  REQ: adp_req_o = 1, adp_* driven from payload reg (never from live inputs).
//   adp_gnt_i: gnt_o[owner] = 1 same cycle (combinational), -> RESP; adp_req_o drops next cycle.
//   Same-cycle adp_gnt_i & adp_valid_i impossible (adapter grants >=1 cycle before valid).
//  RESP: adp_req_o = 0, payload reg held stable (adapter keeps reading wdata/type until
//   its valid). adp_cw_valid_i -> critical_word_valid_o[owner]. adp_valid_i ->
//   valid_o[owner] = 1 same cycle, rdata_o/id_o pass through, rr pointer = owner+1 mod N,
//   -> IDLE.
//  Requester must keep req_i asserted until its gnt_o; req_i dropping in REQ is ignored
//   (payload already latched, transaction completes). Requests arriving during REQ/RESP
//   wait; earliest re-arbitration is the cycle after adp_valid_i (1 idle bubble).
//  Latency: req_i rise in IDLE -> adp_req_o next cycle; gnt_o = adapter grant cycle.
//  Fairness: a continuously requesting port waits at most NR_PORTS-1 transactions.
//  Non-owner ports never see gnt_o/valid_o/critical_word_valid_o asserted.
//  At most one bit of each one-hot output set in any cycle (assertion in RTL).
// TESTING
//  Single port0 read, adapter gnt after 2 cycles, valid 5 cycles later -> gnt_o=001 once,
//   valid_o=001 once, rdata_o = adapter data, adp_req_o high exactly 3 cycles.
//  Ports 0,1,2 request together, continuously -> service order 0,1,2,0,1,2; none starved.
//  Port1 burst write, wdata_i[1] changed after capture -> adapter sees captured wdata
//   until adp_valid_i; gnt_o=010 only when adp_gnt_i.
//  Port2 cacheline read, adp_cw_valid_i mid-burst -> critical_word_valid_o=100 that cycle,
//   critical_word_o = adp_cw_i; ports 0/1 bits stay 0.
//  Port0 drops req_i while in REQ -> transaction still completes, valid_o=001.
//  rst_ni low during RESP -> all outputs 0 async; after release, new port1 request served
//   from rr pointer 0.

Source files
------------

// File: rtl/axi_adapter_arb_32.sv
// Round-robin arbiter that shares one axi_adapter_32 request port among
// NR_PORTS requesters. The winner's payload is latched once and drives the
// adapter until its completion. Grant, valid and critical-word strobes are
// routed back to the owning port only.
module axi_adapter_arb_32 #(
  parameter int NR_PORTS     = 3,
  parameter int DATA_WIDTH   = 64,
  parameter int AXI_ID_WIDTH = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  // requester side
  input  logic [NR_PORTS-1:0]                       req_i,
  input  logic [NR_PORTS-1:0]                       type_i,
  input  logic [NR_PORTS-1:0][31:0]                 addr_i,
  input  logic [NR_PORTS-1:0]                       we_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]       wdata_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0]     be_i,
  input  logic [NR_PORTS-1:0][1:0]                  size_i,
  input  logic [NR_PORTS-1:0][AXI_ID_WIDTH-1:0]     id_i,
  output logic [NR_PORTS-1:0]                       gnt_o,
  output logic [NR_PORTS-1:0]                       valid_o,
  output logic [DATA_WIDTH-1:0]                     rdata_o,
  output logic [AXI_ID_WIDTH-1:0]                   id_o,
  output logic [31:0]                               critical_word_o,
  output logic [NR_PORTS-1:0]                       critical_word_valid_o,
  // adapter side
  output logic                                      adp_req_o,
  output logic                                      adp_type_o,
  output logic [31:0]                               adp_addr_o,
  output logic                                      adp_we_o,
  output logic [DATA_WIDTH-1:0]                     adp_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                   adp_be_o,
  output logic [1:0]                                adp_size_o,
  output logic [AXI_ID_WIDTH-1:0]                   adp_id_o,
  input  logic                                      adp_gnt_i,
  input  logic                                      adp_valid_i,
  input  logic [DATA_WIDTH-1:0]                     adp_rdata_i,
  input  logic [AXI_ID_WIDTH-1:0]                   adp_id_i,
  input  logic [31:0]                               adp_cw_i,
  input  logic                                      adp_cw_valid_i
);

  localparam int PW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  typedef struct packed {
    logic                    typ;
    logic [31:0]             addr;
    logic                    we;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [BW-1:0]           be;
    logic [1:0]              size;
    logic [AXI_ID_WIDTH-1:0] id;
  } payload_t;

  state_t   state_reg, state_next;
  logic [PW-1:0] rr_reg, rr_next;
  logic [PW-1:0] owner_reg, owner_next;
  payload_t payload_reg, payload_next;

  logic [PW-1:0] win;
  logic          any_req;

  // Pick the first requesting port at or after the round-robin pointer.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    any_req = 1'b0;
    for (int i = 0; i < NR_PORTS; i++) begin
      idx = int'(rr_reg) + i;
      if (idx >= NR_PORTS) idx = idx - NR_PORTS;
      if (!any_req && req_i[idx[PW-1:0]]) begin
        any_req = 1'b1;
        win     = idx[PW-1:0];
      end
    end
  end

  // Next-state, payload capture and owner-routed strobes.
  always_comb begin
    state_next            = state_reg;
    rr_next               = rr_reg;
    owner_next            = owner_reg;
    payload_next          = payload_reg;
    gnt_o                 = '0;
    valid_o               = '0;
    critical_word_valid_o = '0;
    adp_req_o             = 1'b0;
    rdata_o               = '0;
    id_o                  = '0;
    critical_word_o       = '0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          owner_next         = win;
          payload_next.typ   = type_i[win];
          payload_next.addr  = addr_i[win];
          payload_next.we    = we_i[win];
          payload_next.wdata = wdata_i[win];
          payload_next.be    = be_i[win];
          payload_next.size  = size_i[win];
          payload_next.id    = id_i[win];
          state_next         = REQ;
        end
      end
      REQ: begin
        adp_req_o = 1'b1;
        if (adp_gnt_i) begin
          gnt_o[owner_reg] = 1'b1;
          state_next       = RESP;
        end
      end
      RESP: begin
        // Read-side data is only forwarded while a transaction is in flight.
        rdata_o         = adp_rdata_i;
        id_o            = adp_id_i;
        critical_word_o = adp_cw_i;
        critical_word_valid_o[owner_reg] = adp_cw_valid_i;
        if (adp_valid_i) begin
          valid_o[owner_reg] = 1'b1;
          rr_next    = (owner_reg == PW'(NR_PORTS - 1)) ? '0 : owner_reg + 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The adapter always sees the latched payload, never live requester inputs.
  assign adp_type_o  = payload_reg.typ;
  assign adp_addr_o  = payload_reg.addr;
  assign adp_we_o    = payload_reg.we;
  assign adp_wdata_o = payload_reg.wdata;
  assign adp_be_o    = payload_reg.be;
  assign adp_size_o  = payload_reg.size;
  assign adp_id_o    = payload_reg.id;

  // State, pointer, owner and payload registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      rr_reg      <= '0;
      owner_reg   <= '0;
      payload_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rr_reg      <= rr_next;
      owner_reg   <= owner_next;
      payload_reg <= payload_next;
    end
  end

  // Owner-routed strobes must never have more than one bit set.
  a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  a_valid_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(valid_o));
  a_cw_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(critical_word_valid_o));

endmodule

// File: tb/tb_axi_adapter_arb_32.sv
// Self-checking bench for axi_adapter_arb_32: a vector table of transactions,
// randomized transactions checked against a round-robin reference model, and
// a hand-written asynchronous reset sequence.
module tb_axi_adapter_arb_32;
  localparam int N   = 3;
  localparam int DW  = 64;
  localparam int IDW = 4;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic [N-1:0]            req_i, type_i, we_i;
  logic [N-1:0][31:0]      addr_i;
  logic [N-1:0][DW-1:0]    wdata_i;
  logic [N-1:0][DW/8-1:0]  be_i;
  logic [N-1:0][1:0]       size_i;
  logic [N-1:0][IDW-1:0]   id_i;
  logic [N-1:0]            gnt_o, valid_o, critical_word_valid_o;
  logic [DW-1:0]           rdata_o;
  logic [IDW-1:0]          id_o;
  logic [31:0]             critical_word_o;
  logic                    adp_req_o, adp_type_o, adp_we_o;
  logic [31:0]             adp_addr_o;
  logic [DW-1:0]           adp_wdata_o;
  logic [DW/8-1:0]         adp_be_o;
  logic [1:0]              adp_size_o;
  logic [IDW-1:0]          adp_id_o;
  logic                    adp_gnt_i, adp_valid_i, adp_cw_valid_i;
  logic [DW-1:0]           adp_rdata_i;
  logic [IDW-1:0]          adp_id_i;
  logic [31:0]             adp_cw_i;

  axi_adapter_arb_32 #(.NR_PORTS(N), .DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .type_i(type_i), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .be_i(be_i), .size_i(size_i), .id_i(id_i),
    .gnt_o(gnt_o), .valid_o(valid_o), .rdata_o(rdata_o), .id_o(id_o),
    .critical_word_o(critical_word_o), .critical_word_valid_o(critical_word_valid_o),
    .adp_req_o(adp_req_o), .adp_type_o(adp_type_o), .adp_addr_o(adp_addr_o),
    .adp_we_o(adp_we_o), .adp_wdata_o(adp_wdata_o), .adp_be_o(adp_be_o),
    .adp_size_o(adp_size_o), .adp_id_o(adp_id_o),
    .adp_gnt_i(adp_gnt_i), .adp_valid_i(adp_valid_i), .adp_rdata_i(adp_rdata_i),
    .adp_id_i(adp_id_i), .adp_cw_i(adp_cw_i), .adp_cw_valid_i(adp_cw_valid_i)
  );

  int n_pass  = 0;
  int n_total = 0;
  int mdl_rr  = 0;   // reference round-robin pointer

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference arbitration: first requesting port at or after the pointer.
  function automatic int model_pick(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      int p;
      p = (mdl_rr + i) % N;
      if (m[p]) return p;
    end
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // One transaction: request mask, grant delay (cycles after entering REQ),
  // completion delay (cycles after grant), critical-word cycle (0 = none).
  task automatic do_txn(input logic [N-1:0] reqm, input int gd, input int vd, input int cwd,
                        input int own, input bit drop, input logic we_all, input string tag);
    logic            e_typ, e_we;
    logic [31:0]     e_addr;
    logic [DW-1:0]   e_wdata, e_rdata;
    logic [DW/8-1:0] e_be;
    logic [1:0]      e_size;
    logic [IDW-1:0]  e_id, e_rid;
    logic [31:0]     e_cw;
    logic [N-1:0]    own_bit;
    int              req_cnt;
    own_bit = '0;
    own_bit[own] = 1'b1;
    for (int p = 0; p < N; p++) begin
      type_i[p]  = 1'($urandom);
      addr_i[p]  = $urandom;
      we_i[p]    = we_all;
      wdata_i[p] = {$urandom, $urandom};
      be_i[p]    = 8'($urandom);
      size_i[p]  = 2'($urandom);
      id_i[p]    = 4'($urandom);
    end
    e_typ = type_i[own]; e_addr = addr_i[own]; e_we = we_i[own];
    e_wdata = wdata_i[own]; e_be = be_i[own]; e_size = size_i[own]; e_id = id_i[own];
    req_i = reqm;
    next_cycle();
    // now in REQ: disturb the owner's live inputs, the adapter must not notice
    if (drop) req_i[own] = 1'b0;
    wdata_i[own] = ~wdata_i[own];
    addr_i[own]  = addr_i[own] ^ 32'hffff_0000;
    req_cnt = 0;
    for (int c = 0; c < gd; c++) begin
      req_cnt += int'(adp_req_o);
      chk({tag, " gnt_wait"}, 64'(gnt_o), 64'd0);
      next_cycle();
    end
    req_cnt += int'(adp_req_o);
    chk({tag, " adp_addr"},  64'(adp_addr_o), 64'(e_addr));
    chk({tag, " adp_wdata"}, adp_wdata_o, e_wdata);
    chk({tag, " adp_ctl"},   64'({adp_type_o, adp_we_o, adp_be_o, adp_size_o, adp_id_o}),
                             64'({e_typ, e_we, e_be, e_size, e_id}));
    adp_gnt_i = 1'b1;
    #1;
    chk({tag, " gnt"}, 64'(gnt_o), 64'(own_bit));
    next_cycle();
    adp_gnt_i = 1'b0;
    req_i[own] = 1'b0;
    for (int k = 1; k <= vd; k++) begin
      req_cnt += int'(adp_req_o);
      e_cw = $urandom;
      e_rdata = {$urandom, $urandom};
      e_rid = 4'($urandom);
      adp_cw_i = e_cw;
      adp_cw_valid_i = (k == cwd);
      adp_rdata_i = e_rdata;
      adp_id_i = e_rid;
      adp_valid_i = (k == vd);
      #1;
      chk({tag, " cw_valid"}, 64'(critical_word_valid_o), (k == cwd) ? 64'(own_bit) : 64'd0);
      if (k == cwd) chk({tag, " cw"}, 64'(critical_word_o), 64'(e_cw));
      chk({tag, " wdata_hold"}, adp_wdata_o, e_wdata);
      chk({tag, " valid"}, 64'(valid_o), (k == vd) ? 64'(own_bit) : 64'd0);
      if (k == vd) begin
        chk({tag, " rdata"}, rdata_o, e_rdata);
        chk({tag, " rid"}, 64'(id_o), 64'(e_rid));
      end
      next_cycle();
      adp_valid_i = 1'b0;
      adp_cw_valid_i = 1'b0;
    end
    chk({tag, " req_cycles"}, 64'(req_cnt), 64'(gd + 1));
    $display("txn %s: mask=%b owner=%0d gd=%0d vd=%0d cw=%0d drop=%0d", tag, reqm, own, gd, vd, cwd, drop);
    mdl_rr = (own + 1) % N;
  endtask

  typedef struct {
    logic [N-1:0] req;
    int           gd;
    int           vd;
    int           cwd;
    int           exp_owner;
    bit           drop;
    logic         we;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // Hand-derived vectors; pointer starts at 0 after reset.
    vecs[0]  = '{3'b111, 1, 2, 0, 0, 1'b0, 1'b0};
    vecs[1]  = '{3'b111, 1, 2, 0, 1, 1'b0, 1'b0};
    vecs[2]  = '{3'b111, 1, 2, 0, 2, 1'b0, 1'b0};
    vecs[3]  = '{3'b111, 1, 2, 0, 0, 1'b0, 1'b0};
    vecs[4]  = '{3'b111, 1, 2, 0, 1, 1'b0, 1'b0};
    vecs[5]  = '{3'b111, 1, 2, 0, 2, 1'b0, 1'b0};
    vecs[6]  = '{3'b001, 2, 5, 0, 0, 1'b0, 1'b0};  // single read, 3 request cycles
    vecs[7]  = '{3'b010, 1, 4, 0, 1, 1'b0, 1'b1};  // port1 write, live wdata changed
    vecs[8]  = '{3'b100, 0, 6, 3, 2, 1'b0, 1'b0};  // port2 line read, critical word
    vecs[9]  = '{3'b001, 2, 3, 0, 0, 1'b1, 1'b0};  // port0 drops req in REQ
    vecs[10] = '{3'b101, 0, 1, 1, 2, 1'b0, 1'b0};  // pointer at 1 -> port2
    vecs[11] = '{3'b110, 3, 2, 0, 1, 1'b0, 1'b1};  // pointer at 0 -> port1
    vecs[12] = '{3'b011, 1, 1, 0, 0, 1'b0, 1'b0};  // pointer at 2 -> wraps to port0

    rst_ni = 1'b0;
    req_i = '0; type_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    be_i = '0; size_i = '0; id_i = '0;
    adp_gnt_i = 1'b0; adp_valid_i = 1'b0; adp_cw_valid_i = 1'b0;
    adp_rdata_i = '0; adp_id_i = '0; adp_cw_i = '0;
    repeat (3) next_cycle();
    chk("reset adp_req", 64'(adp_req_o), 64'd0);
    chk("reset strobes", 64'({gnt_o, valid_o, critical_word_valid_o}), 64'd0);
    chk("reset payload", 64'(adp_addr_o), 64'd0);
    rst_ni = 1'b1;
    next_cycle();
    chk("idle adp_req", 64'(adp_req_o), 64'd0);

    for (int v = 0; v < 13; v++)
      do_txn(vecs[v].req, vecs[v].gd, vecs[v].vd, vecs[v].cwd, vecs[v].exp_owner,
             vecs[v].drop, vecs[v].we, $sformatf("vec%0d", v));

    // Randomized transactions against the round-robin model.
    for (int r = 0; r < 24; r++) begin
      logic [N-1:0] m;
      int gd, vd;
      m  = 3'($urandom_range(1, 7));
      gd = $urandom_range(0, 3);
      vd = $urandom_range(1, 5);
      do_txn(m, gd, vd, $urandom_range(0, vd), model_pick(m), 1'b0, 1'($urandom),
             $sformatf("rnd%0d", r));
    end

    // Move the pointer to 2, then abandon a transaction with reset in RESP.
    do_txn(3'b010, 1, 2, 0, model_pick(3'b010), 1'b0, 1'b0, "pre_rst");
    req_i = 3'b001;
    next_cycle();
    adp_gnt_i = 1'b1;
    next_cycle();
    adp_gnt_i = 1'b0;
    req_i = '0;
    chk("resp adp_req", 64'(adp_req_o), 64'd0);
    adp_cw_valid_i = 1'b1;
    adp_valid_i = 1'b1;
    #1;
    chk("pre_rst valid", 64'(valid_o), 64'b001);
    rst_ni = 1'b0;
    #1;
    chk("async rst strobes", 64'({gnt_o, valid_o, critical_word_valid_o}), 64'd0);
    chk("async rst adp", 64'({adp_req_o, adp_addr_o}), 64'd0);
    adp_cw_valid_i = 1'b0;
    adp_valid_i = 1'b0;
    $display("txn reset: asserted during RESP");
    repeat (2) next_cycle();
    rst_ni = 1'b1;
    mdl_rr = 0;
    next_cycle();
    do_txn(3'b110, 1, 2, 0, 1, 1'b0, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
